// File: rtl/avalon_edge_irq_pio.sv
`default_nettype none
// ============================================================================
// Module      : avalon_edge_irq_pio
// Description : Avalon-MM input PIO with per-bit synchroniser, programmable
//               debounce, rising/falling edge capture (write-1-to-clear) and
//               a level IRQ to the CPU. One instance serves one input group.
// Ports       : clk, reset_n (async, active low)
//               address/chipselect/write_n/writedata : Avalon slave write side
//               readdata : registered read data, 1-cycle latency
//               in_port  : raw asynchronous inputs, WIDTH bits
//               irq      : OR of captured edges masked by IRQ_MASK
// Register map: 0 DATA (RO), 1 RISE_EN, 2 IRQ_MASK, 3 EDGE_CAP (W1C),
//               4 FALL_EN, 5 DEBOUNCE, 6/7 read 0
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_edge_irq_pio #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 16,
   parameter int DEB_RESET = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [2:0] c_addr_data   = 3'd0;
   localparam logic [2:0] c_addr_rise   = 3'd1;
   localparam logic [2:0] c_addr_mask   = 3'd2;
   localparam logic [2:0] c_addr_cap    = 3'd3;
   localparam logic [2:0] c_addr_fall   = 3'd4;
   localparam logic [2:0] c_addr_deb    = 3'd5;

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_dly_q;
   logic [WIDTH-1:0] rise_en_d, rise_en_q;
   logic [WIDTH-1:0] fall_en_d, fall_en_q;
   logic [WIDTH-1:0] mask_d, mask_q;
   logic [WIDTH-1:0] cap_d, cap_q;
   logic [CNT_W-1:0] deb_thr_d, deb_thr_q;
   logic [31:0]      readdata_d, readdata_q;

   logic             wr;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   // Upper write-data bits beyond WIDTH/CNT_W are ignored by design.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr   = chipselect & ~write_n;
   assign clr  = (wr && address == c_addr_cap) ? writedata[WIDTH-1:0] : '0;
   assign rise = deb & ~deb_dly_q & rise_en_q;
   assign fall = ~deb & deb_dly_q & fall_en_q;

   // --------------------------------------------------------------------------
   // Per-channel debounce. A new level is accepted only after it has differed
   // from the current debounced state for DEBOUNCE consecutive cycles. The
   // ">=" compare makes a threshold lowered mid-count take effect at once.
   // --------------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CNT_W-1:0] cnt_d, cnt_q;
      logic             deb_bit_d, deb_bit_q;

      always_comb begin
         cnt_d     = cnt_q;
         deb_bit_d = deb_bit_q;
         if (deb_thr_q == '0) begin
            deb_bit_d = s2_q[i];
            cnt_d     = '0;
         end else if (s2_q[i] == deb_bit_q) begin
            cnt_d     = '0;
         end else if (cnt_q >= deb_thr_q - CNT_W'(1)) begin
            deb_bit_d = s2_q[i];
            cnt_d     = '0;
         end else begin
            cnt_d     = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q     <= '0;
            deb_bit_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            deb_bit_q <= deb_bit_d;
         end
      end

      assign deb[i] = deb_bit_q;
   end

   // --------------------------------------------------------------------------
   // Register next-state and read mux
   // --------------------------------------------------------------------------
   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      mask_d    = mask_q;
      deb_thr_d = deb_thr_q;
      if (wr) begin
         case (address)
            c_addr_rise: rise_en_d = writedata[WIDTH-1:0];
            c_addr_mask: mask_d    = writedata[WIDTH-1:0];
            c_addr_fall: fall_en_d = writedata[WIDTH-1:0];
            c_addr_deb:  deb_thr_d = writedata[CNT_W-1:0];
            default: ;
         endcase
      end
      // A fresh edge wins over a simultaneous clear of the same bit.
      cap_d = (cap_q & ~clr) | rise | fall;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         c_addr_data: readdata_d[WIDTH-1:0] = deb;
         c_addr_rise: readdata_d[WIDTH-1:0] = rise_en_q;
         c_addr_mask: readdata_d[WIDTH-1:0] = mask_q;
         c_addr_cap:  readdata_d[WIDTH-1:0] = cap_q;
         c_addr_fall: readdata_d[WIDTH-1:0] = fall_en_q;
         c_addr_deb:  readdata_d[CNT_W-1:0] = deb_thr_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_dly_q  <= '0;
         rise_en_q  <= '1;
         fall_en_q  <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         deb_thr_q  <= CNT_W'(DEB_RESET);
         readdata_q <= '0;
      end else begin
         s1_q       <= in_port;
         s2_q       <= s1_q;
         deb_dly_q  <= deb;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         deb_thr_q  <= deb_thr_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_avalon_edge_irq_pio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_avalon_edge_irq_pio
// Description : Scoreboard bench for avalon_edge_irq_pio. Stimulus issues
//               Avalon reads and pushes the hand-computed readdata/irq pair;
//               a monitor pops and compares when the read data is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_edge_irq_pio;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  in_port = '0;
   logic        irq;

   typedef struct {
      logic [31:0] rd;
      logic        irq;
      string       name;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  rd_req = 1'b0;
   logic  rd_pending;
   event  probe_ev;

   always #5 clk = ~clk;

   avalon_edge_irq_pio #(.WIDTH(8), .CNT_W(16), .DEB_RESET(0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   // A read issued in one cycle presents its data after the next rising edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_pending <= 1'b0;
      else          rd_pending <= rd_req;
   end

   task automatic check_item();
      item_t it;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_output: readdata=%h irq=%b with empty scoreboard", readdata, irq);
      end else begin
         it = sb.pop_front();
         checks++;
         if (readdata !== it.rd) begin
            errors++;
            $display("FAIL %s readdata: got %h expected %h", it.name, readdata, it.rd);
         end
         checks++;
         if (irq !== it.irq) begin
            errors++;
            $display("FAIL %s irq: got %b expected %b", it.name, irq, it.irq);
         end
      end
   endtask

   always @(negedge clk) if (rd_pending) check_item();
   always @(probe_ev) check_item();

   // Each task starts just after a falling edge and consumes one clock cycle.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input logic ei, input string nm);
      item_t it;
      it.rd = e; it.irq = ei; it.name = nm;
      sb.push_back(it);
      address = a; rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   initial begin
      item_t it;
      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;

      // Reset values of the whole map
      rd(3'd0, 32'h00, 1'b0, "rst_data");
      rd(3'd1, 32'hFF, 1'b0, "rst_rise_en");
      rd(3'd2, 32'h00, 1'b0, "rst_mask");
      rd(3'd3, 32'h00, 1'b0, "rst_cap");
      rd(3'd4, 32'h00, 1'b0, "rst_fall_en");
      rd(3'd5, 32'h00, 1'b0, "rst_debounce");
      rd(3'd6, 32'h00, 1'b0, "rst_addr6");
      rd(3'd7, 32'h00, 1'b0, "rst_addr7");

      // Bypass debounce: capture lands on the 4th edge after the change
      in_port = 8'h01;
      idle(2);
      rd(3'd0, 32'h00, 1'b0, "lat_data_e3");
      rd(3'd3, 32'h00, 1'b0, "lat_cap_e4");
      rd(3'd3, 32'h01, 1'b0, "lat_cap_e5");
      rd(3'd0, 32'h01, 1'b0, "lat_data_e6");

      // IRQ mask and write-1-to-clear
      wr(3'd2, 32'h01);
      rd(3'd2, 32'h01, 1'b1, "irq_on");
      wr(3'd3, 32'h01);
      rd(3'd3, 32'h00, 1'b0, "w1c_clear");

      // Falling-edge only on bit 7
      wr(3'd1, 32'h00);
      wr(3'd4, 32'h80);
      in_port = 8'h81; idle(6);
      rd(3'd3, 32'h00, 1'b0, "rise_disabled");
      in_port = 8'h01; idle(6);
      rd(3'd3, 32'h80, 1'b0, "fall_cap");
      in_port = 8'h81; idle(6);
      rd(3'd3, 32'h80, 1'b0, "no_new_rise");
      wr(3'd3, 32'h00);
      rd(3'd3, 32'h80, 1'b0, "w1c_zero_keeps");
      wr(3'd2, 32'h80);
      rd(3'd2, 32'h80, 1'b1, "irq_bit7");
      wr(3'd4, 32'h00);
      rd(3'd3, 32'h80, 1'b1, "disable_keeps");
      wr(3'd3, 32'h80);
      rd(3'd3, 32'h00, 1'b0, "w1c_bit7");

      // Debounce threshold 5: 4-cycle glitch rejected, 5 cycles accepted
      wr(3'd1, 32'hFF);
      wr(3'd5, 32'h0005);
      rd(3'd5, 32'h05, 1'b0, "deb_reg");
      in_port = 8'h85; idle(4);
      in_port = 8'h81; idle(8);
      rd(3'd0, 32'h81, 1'b0, "glitch_data");
      rd(3'd3, 32'h00, 1'b0, "glitch_cap");
      in_port = 8'h85; idle(5);
      rd(3'd0, 32'h81, 1'b0, "deb_data_e6");
      rd(3'd0, 32'h81, 1'b0, "deb_data_e7");
      rd(3'd0, 32'h85, 1'b0, "deb_data_e8");
      rd(3'd3, 32'h04, 1'b0, "deb_cap");

      // Edge and clear of the same bit in the same cycle: edge wins
      wr(3'd5, 32'h0000);
      in_port = 8'h8D; idle(3);
      wr(3'd3, 32'h08);
      rd(3'd3, 32'h0C, 1'b0, "edge_beats_clear");
      wr(3'd3, 32'h08);
      rd(3'd3, 32'h04, 1'b0, "clear_bit3");

      // Fill EDGE_CAP then reset mid-debounce
      wr(3'd4, 32'hFF);
      in_port = 8'hFF; idle(6);
      in_port = 8'h00; idle(6);
      rd(3'd3, 32'hFF, 1'b1, "cap_full");
      wr(3'd2, 32'hFF);
      rd(3'd2, 32'hFF, 1'b1, "mask_full");
      wr(3'd5, 32'h0005);
      in_port = 8'hFF; idle(3);
      #2 reset_n = 1'b0;
      #1;
      it.rd = 32'h0; it.irq = 1'b0; it.name = "async_reset";
      sb.push_back(it);
      -> probe_ev;
      idle(2);
      reset_n = 1'b1;
      rd(3'd0, 32'h00, 1'b0, "post_rst_data");
      rd(3'd3, 32'h00, 1'b0, "post_rst_cap");
      rd(3'd2, 32'h00, 1'b0, "post_rst_mask");
      rd(3'd1, 32'hFF, 1'b0, "post_rst_rise_en");
      rd(3'd5, 32'h00, 1'b0, "post_rst_debounce");

      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected responses never presented, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
